// File: rtl/param_seq_detector_if.sv
// Serial-bit bus for param_seq_detector.
// Count signals exist only when SEQ_DET_COUNT_EN is defined.
interface param_seq_detector_if #(
    parameter int PAT_LEN = 3
`ifdef SEQ_DET_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
);
    logic               en;
    logic               x;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               y;
`ifdef SEQ_DET_COUNT_EN
    logic               cnt_clr;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output en, x, overlap, pat_load, pat_in, cnt_clr,
        input  y, match_cnt
    );
    modport slave (
        input  en, x, overlap, pat_load, pat_in, cnt_clr,
        output y, match_cnt
    );
`else
    modport master (
        output en, x, overlap, pat_load, pat_in,
        input  y
    );
    modport slave (
        input  en, x, overlap, pat_load, pat_in,
        output y
    );
`endif
endinterface

// File: rtl/param_seq_detector.sv
// Run-time programmable Mealy serial-pattern detector.
// SEQ_DET_COUNT_EN adds a saturating match counter.
module param_seq_detector #(
    parameter int                 PAT_LEN     = 3,
    parameter logic [PAT_LEN-1:0] RST_PATTERN = 3'b011,
    parameter int                 CNT_W       = 8
) (
    input logic                 clk,
    input logic                 reset,
    param_seq_detector_if.slave bus
);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN - 1);

    if (PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1) begin : g_bad_cfg
        $error("param_seq_detector: illegal PAT_LEN or CNT_W");
    end

    logic [PAT_LEN-1:0] pat_r;
    logic [PAT_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] window;
    logic               full;
    logic               hit;

    assign window = {hist, bus.x};
    assign full   = (fill == FULL);
    assign hit    = bus.en & ~bus.pat_load & ~reset
                  & full & (window == pat_r);
    assign bus.y  = hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r <= RST_PATTERN;
            hist  <= '0;
            fill  <= '0;
        end else if (bus.pat_load) begin
            pat_r <= bus.pat_in;
            hist  <= '0;
            fill  <= '0;
        end else if (bus.en) begin
            // Non-overlap match: consumed bits never seed the next match
            if (hit && !bus.overlap) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[PAT_LEN-2:0];
                fill <= full ? fill : fill + FW'(1);
            end
        end
    end

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.cnt_clr) begin
            cnt <= '0;
        end else if (hit && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt;
`endif
endmodule
